serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 43 ++++
 rtl/serial_add_ctrl_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and default width for the serial adder
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result handshake bundle, sub_i present under SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_i;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_i;
`endif
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;
  logic             busy_o;

  // Producer/sink side: drives operands and result acceptance.
  modport master (
    output in_valid_i, a_i, b_i, c_i,
`ifdef SERIAL_ADD_SUB_EN
    output sub_i,
`endif
    output out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, carry_o, ovf_o, busy_o
  );

  // Adder side.
  modport slave (
    input  in_valid_i, a_i, b_i, c_i,
`ifdef SERIAL_ADD_SUB_EN
    input  sub_i,
`endif
    input  out_ready_i,
    output in_ready_o, out_valid_o, sum_o, carry_o, ovf_o, busy_o
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// rtl/serial_add_ctrl_fa.sv - 1-bit full-adder cell
module serial_add_ctrl_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer, optional subtract via SERIAL_ADD_SUB_EN
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             res_carry_q, res_carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sub;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_shifted;

`ifdef SERIAL_ADD_SUB_EN
  assign sub = bus.sub_i;
`else
  assign sub = 1'b0;
`endif

  serial_add_ctrl_fa u_fa (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
  assign sum_shifted = {fa_sum, {(WIDTH-1){1'b0}}} | (sum_sh_q >> 1);

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    res_carry_d = res_carry_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          // Subtraction is A + ~B + 1, so the carry-in is forced high.
          a_sh_d   = bus.a_i;
          b_sh_d   = bus.b_i ^ {WIDTH{sub}};
          carry_d  = sub | bus.c_i;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted;
        carry_d  = fa_carry;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB; disagreement with carry out means signed overflow.
          sum_d       = sum_shifted;
          res_carry_d = fa_carry;
          ovf_d       = carry_q ^ fa_carry;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      res_carry_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      res_carry_q <= res_carry_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.busy_o      = (state_q == ST_RUN);
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = res_carry_q;
  assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer add of A, B (or ~B) and carry-in; signed overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : c)};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic sub);
    bus.a_i = a;
    bus.b_i = b;
    bus.c_i = c;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub_i = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", 64'(bus.in_ready_o), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit scramble, input int hold);
    int cyc;
    int busy_cycles;
    logic [W-1:0] held;
    wait_ready();
    drive_ops(a, b, c, sub);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    drive_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    cyc = 0;
    busy_cycles = 0;
    while (!bus.out_valid_o && cyc < 40) begin
      busy_cycles += int'(bus.busy_o);
      if (scramble) begin
        drive_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        bus.out_ready_i = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready_i = 1'b0;
    check("latency", 64'(cyc), 64'(W));
    check("busy_cycles", 64'(busy_cycles), 64'(W));
    check("busy_in_done", 64'(bus.busy_o), 64'(0));
    check("sum", 64'(bus.sum_o), 64'(es));
    check("carry", 64'(bus.carry_o), 64'(ec));
    check("ovf", 64'(bus.ovf_o), 64'(eo));
    held = bus.sum_o;
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        drive_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        bus.in_valid_i = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      check("bp_valid", 64'(bus.out_valid_o), 64'(1));
      check("bp_sum", 64'(bus.sum_o), 64'(held));
      check("bp_in_ready", 64'(bus.in_ready_o), 64'(0));
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("release_valid", 64'(bus.out_valid_o), 64'(0));
    check("release_ready", 64'(bus.in_ready_o), 64'(1));
    check("release_busy", 64'(bus.busy_o), 64'(0));
    check("release_sum_held", 64'(bus.sum_o), 64'(held));
  endtask

  task automatic run_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic sub, input bit scramble, input int hold);
    logic [W+1:0] r;
    r = model(a, b, c, sub);
    run_op(a, b, c, sub, r[W-1:0], r[W], r[W+1], scramble, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'(1));
    check({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
    check({tag, "_sum"}, 64'(bus.sum_o), 64'(0));
    check({tag, "_carry"}, 64'(bus.carry_o), 64'(0));
    check({tag, "_ovf"}, 64'(bus.ovf_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    logic sub_r;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed additions.
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);

    // Backpressure with an ignored in_valid pulse in DONE.
    run_model(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, 5);

    // Operands and out_ready wiggled through RUN.
    run_model(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 1'b1, 0);

    // Asynchronous reset part-way through RUN.
    wait_ready();
    drive_ops(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen_valid += int'(bus.out_valid_o);
    end
    check("no_valid_after_reset", 64'(seen_valid), 64'(0));
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
`endif

    // Random operations against the model.
    for (int k = 0; k < 30; k++) begin
`ifdef SERIAL_ADD_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      run_model(16'($urandom), 16'($urandom), 1'($urandom), sub_r,
                1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
